// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between the instruction-fetch and data miss paths.
// Build option: define ARB_ROUND_ROBIN_EN for alternating grants on contention (default: data side wins).
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  // state | meaning
  // IDLE  | sample requests, grant one side
  // SERVE | command held on the memory port for LATENCY cycles
  // DONE  | one-cycle done pulse to the owner
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner_d;
  logic       lat_we;
  logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_comb grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk) begin
    if (!reset_n)
      last_d <= 1'b0;
    else if (state == IDLE && (d_req || i_req))
      last_d <= grant_d;
  end
`else
  always_comb grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_d   <= 1'b0;
      lat_we    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          if (d_req || i_req) begin
            owner_d <= grant_d;
            cnt     <= 4'd0;
            busy    <= 1'b1;
            state   <= SERVE;
            if (grant_d) begin
              m_address <= d_addr;
              lat_we    <= d_we;
              m_readM   <= ~d_we;
              m_writeM  <= d_we;
              if (d_we)
                m_wdata <= d_wdata;
            end else begin
              m_address <= i_addr;
              lat_we    <= 1'b0;
              m_readM   <= 1'b1;
              m_writeM  <= 1'b0;
            end
          end
        end
        SERVE: begin
          // writes only strobe once; reads stay asserted for the whole window
          m_writeM <= 1'b0;
          cnt      <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            m_readM <= 1'b0;
            if (!lat_we) begin
              if (owner_d)
                d_rdata <= m_rdata;
              else
                i_rdata <= m_rdata;
            end
            d_done <= owner_d;
            i_done <= ~owner_d;
            state  <= DONE;
          end
        end
        DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read main memory between the instruction-fetch miss path (read-only) and the data miss/write path.
- Sequences each access:
  - latches the command;
  - holds it on the memory port for a fixed latency;
  - captures read data;
  - returns a one-cycle done pulse to the owning requester.
- Sits between the cache controllers and the memory model.

Parameters:
- WORD_SIZE, 16, address and data width.
- LATENCY, 2, cycles the command is held on the memory port (SERVE cycles); legal range 2..15.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- i_req  input  1  instruction-side read request, level, held until i_done
- i_addr  input  WORD_SIZE  instruction read address
- i_rdata  output  WORD_SIZE  instruction read data, valid when i_done=1, held afterwards
- i_done  output  1  one-cycle completion pulse for the instruction side
- d_req  input  1  data-side request, level, held until d_done
- d_we  input  1  1 = write, 0 = read
- d_addr  input  WORD_SIZE  data address
- d_wdata  input  WORD_SIZE  write data
- d_rdata  output  WORD_SIZE  data read data, valid when d_done=1, held afterwards
- d_done  output  1  one-cycle completion pulse for the data side
- m_readM  output  1  memory read enable
- m_writeM  output  1  memory write enable
- m_address  output  WORD_SIZE  memory address
- m_wdata  output  WORD_SIZE  memory write data
- m_rdata  input  WORD_SIZE  memory read data, registered by memory one clock after m_readM
- busy  output  1  high in SERVE and DONE

Behaviour:
- Reset: reset_n is synchronous, active-low, on clk.
  - Reset values: state=IDLE, cnt=0, owner=I, all outputs 0.
  - Any in-flight transaction is dropped and no done pulse is issued.
  - Reset wins over every other event in the same cycle.
- FSM states: IDLE, SERVE, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - d_req=1 → owner=D; latch d_addr, d_we, d_wdata.
  - Else i_req=1 → owner=I; latch i_addr with we=0.
  - Then cnt←0 and go to SERVE.
  - No request → stay in IDLE.
  - Fixed priority: D beats I when both are high.
- SERVE (LATENCY cycles):
  - m_address is driven with the latched address throughout.
  - Read: m_readM=1 for all SERVE cycles.
  - Write: m_writeM=1 only in the first SERVE cycle (cnt==0), with m_wdata = latched data; m_writeM=0 for the remaining cycles.
  - cnt increments each cycle.
  - At the edge ending cnt==LATENCY-1: capture m_rdata into the owner's rdata register (reads only), then go to DONE.
- DONE (one cycle):
  - The owner's done=1; the other side's done=0.
  - m_readM=m_writeM=0.
  - Next state is IDLE.
- Outside SERVE: m_readM=m_writeM=0; m_address and m_wdata hold their last values.
- Latency: request in cycle 0 (IDLE) → SERVE in cycles 1..LATENCY → done in cycle LATENCY+1. After DONE, at least one IDLE cycle occurs before the next grant.
- Requester rule:
  - Requester deasserts req in the cycle after done; a req still high in IDLE is taken as a new request.
  - Changes to addr/we/wdata after the grant are ignored.
- Write completion: d_done pulses and d_rdata is unchanged.
- Never-updated rdata: i_rdata and d_rdata hold 0 until their first read completes.
- Width: cnt is 4 bits; no arithmetic on data.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are high in IDLE, grant goes to the side not served by the most recent grant.
  - The last-served register resets to I, so D wins the first contest.
  - A single request is granted regardless of history.
- Undefined: fixed D-over-I priority as described in Behaviour; no history register.

Test Plan (all with LATENCY=2):
- I read: memory[0x23]=0x6000, i_req=1, i_addr=0x23 at cycle 0 → m_readM=1 in cycles 1-2; i_done=1 in cycle 3 only; i_rdata=0x6000; d_done stays 0.
- D write then read:
  - d_we=1, addr 0x10, wdata 0xBEEF → m_writeM=1 in cycle 1 only; d_done in cycle 3.
  - Then a read of 0x10 → d_rdata=0xBEEF on the second d_done.
- Simultaneous requests: i_req and d_req both high in cycle 0.
  - D done in cycle 3; I granted in cycle 4 and done in cycle 7.
  - Both requests re-raised together: fixed priority → D wins again; with ARB_ROUND_ROBIN_EN → I wins.
- Reset mid-operation: reset_n=0 in cycle 2 (SERVE) for one cycle → state IDLE; no i_done/d_done pulse; m_readM=0; busy=0. A fresh request afterwards completes normally with LATENCY+1 timing.
- Back-to-back D reads: reads of 0x1 then 0x2 (values 0x0001, 0xFFFF); d_req dropped for one cycle after each done → both complete with correct data; no extra grants while busy.
- Request during busy: i_req rises in cycle 1 while D is in SERVE → I is not granted until the IDLE cycle after d_done; then completes with correct data.
